// File: rtl/majority4_pkg.sv
// Shared types and constants for the 4-input majority response checker.
// Holds the checker state encoding, coverage/counter constants and helpers.
package majority4_pkg;

    localparam int CNT_W = 8;

    localparam logic [15:0] FULL_COVERAGE = 16'hFFFF;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    // Counter increment that sticks at the top value.
    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [2:0] popcount4(
        input logic [3:0] v
    );
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/majority4_ref.sv
// Combinational reference model of the 4-input majority block.
// Ports: vec (4-bit input vector {A,B,C,D}), y_exp (expected Y).
module majority4_ref
    import majority4_pkg::*;
#(
    parameter bit TIE_VALUE = 1'b0
) (
    input  logic [3:0] vec,
    output logic       y_exp
);

    logic [2:0] ones;

    assign ones = popcount4(vec);

    // A 2-2 split has no majority; the tie value decides it.
    always_comb begin
        y_exp = 1'b0;
        unique case (1'b1)
            (ones >= 3'd3): y_exp = 1'b1;
            (ones == 3'd2): y_exp = TIE_VALUE;
            default:        y_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/majority4_checker.sv
// Self-checking response monitor for the 4-input majority block.
// Inputs: clk, rst_n, start, sample, A..D, Y.
// Outputs: busy, done, pass, err_count, vec_count, coverage,
//          first_fail_valid, first_fail_vec (all registered).
module majority4_checker
    import majority4_pkg::*;
#(
    parameter bit TIE_VALUE    = 1'b0,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             Y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [15:0]      coverage,
    output logic             first_fail_valid,
    output logic [3:0]       first_fail_vec
);

    state_t           state;
    state_t           state_n;
    logic [3:0]       idx;
    logic             y_exp;
    logic             take;
    logic             mism;
    logic [CNT_W-1:0] err_n;
    logic [CNT_W-1:0] vec_n;
    logic [15:0]      cov_n;
    logic             ffv_n;
    logic [3:0]       ffvec_n;
    logic             busy_n;
    logic             done_n;
    logic             pass_n;

    assign idx = {A, B, C, D};

    majority4_ref #(
        .TIE_VALUE (TIE_VALUE)
    ) u_ref (
        .vec   (idx),
        .y_exp (y_exp)
    );

    // start has priority: a sample coinciding with it is dropped.
    assign take = (state == RUN) && sample && !start;
    assign mism = take && (Y != y_exp);

    always_comb begin
        state_n = state;
        err_n   = err_count;
        vec_n   = vec_count;
        cov_n   = coverage;
        ffv_n   = first_fail_valid;
        ffvec_n = first_fail_vec;
        if (start) begin
            state_n = RUN;
            err_n   = '0;
            vec_n   = '0;
            cov_n   = '0;
            ffv_n   = 1'b0;
            ffvec_n = '0;
        end else if (take) begin
            vec_n = sat_inc(vec_count);
            cov_n = coverage | (16'h0001 << idx);
            if (mism) begin
                err_n = sat_inc(err_count);
                if (!first_fail_valid) begin
                    ffv_n   = 1'b1;
                    ffvec_n = idx;
                end
            end
            // A stopping mismatch beats completion on the same sample.
            if (mism && STOP_ON_FAIL) begin
                state_n = FAIL;
            end else if (cov_n == FULL_COVERAGE) begin
                state_n = DONE;
            end
        end
    end

    // Flag outputs are computed from next state so they stay registered.
    always_comb begin
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE) || (state_n == FAIL);
        pass_n = done_n && (err_n == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            err_count        <= '0;
            vec_count        <= '0;
            coverage         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
        end else begin
            state            <= state_n;
            err_count        <= err_n;
            vec_count        <= vec_n;
            coverage         <= cov_n;
            first_fail_valid <= ffv_n;
            first_fail_vec   <= ffvec_n;
            busy             <= busy_n;
            done             <= done_n;
            pass             <= pass_n;
        end
    end

endmodule

// File: doc/majority4_checker.md
# majority4_checker

Synchronous self-checking response monitor for the 4-input majority block. The stimulus side drives the A–D inputs of the device under test; this block sits on the other side of that interface. It samples the device's inputs and its Y output on a strobe and compares Y against an internal reference model. It also accumulates coverage of all 16 input combinations and reports pass/fail. It is synthesizable, so the lab exercise can run on the board as well as in simulation.

## Interface
Parameters:
- TIE_VALUE, 0, expected Y when exactly two of A..D are 1 (0 or 1).
- STOP_ON_FAIL, 0, 1 = freeze in FAIL on first mismatch; 0 = keep counting.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; clears all results and arms checking.
- sample  input  1  A..D and Y are valid this cycle; check them.
- A, B, C, D  input  1 each  DUT inputs; vector index = {A,B,C,D}, A is MSB.
- Y  input  1  DUT output under check.
- busy  output  1  state is RUN.
- done  output  1  state is DONE or FAIL.
- pass  output  1  done and err_count == 0.
- err_count  output  8  mismatch count, saturates at 255.
- vec_count  output  8  accepted samples, saturates at 255.
- coverage  output  16  bit i set once vector index i has been sampled.
- first_fail_valid  output  1  first_fail_vec holds a failing vector.
- first_fail_vec  output  4  index of the first mismatching vector.

## Operation
- States: IDLE, RUN, DONE, FAIL.
- IDLE:
  - start moves the block to RUN.
  - sample is ignored.
- RUN, on each sample:
  - increment vec_count and set coverage[idx].
  - Compute expected Y:
    - popcount ≥ 3 → 1.
    - popcount == 2 → TIE_VALUE.
    - popcount ≤ 1 → 0.
  - On mismatch, increment err_count. If first_fail_valid is 0, capture idx and set first_fail_valid.
- Transitions out of RUN:
  - Mismatch with STOP_ON_FAIL=1 → FAIL. The failing sample is counted.
  - coverage becomes 16'hFFFF (including the bit set by the current sample) and no stopping mismatch → DONE.
  - If both conditions hit on the same sample, FAIL wins.
- DONE and FAIL hold all results. sample is ignored. start re-arms to RUN.
- start in any state, including RUN:
  - clears err_count, vec_count, coverage and first_fail_valid/vec.
  - moves to RUN.
  - A sample in the same cycle is discarded.
- Repeated vectors are counted in vec_count, re-checked, and leave coverage unchanged.
- Saturating counters stay at 255. Saturation does not affect state transitions.

## Timing
- Reset (rst_n low, asynchronous) gives:
  - state IDLE.
  - busy=0, done=0, pass=0.
  - err_count=0, vec_count=0, coverage=0.
  - first_fail_valid=0, first_fail_vec=0.
- Reset asserted mid-RUN discards all results immediately.
- Latency: a sample at edge N appears in counters, coverage and state after edge N, i.e. visible in cycle N+1.
- done and pass rise in the cycle after the completing sample.
- busy rises in the cycle after start.
- All outputs are registered. No combinational path from inputs to outputs.
- sample may be asserted every cycle (back-to-back). No handshake back-pressure.

## Structure
- Package majority4_pkg holds:
  - state enum (IDLE, RUN, DONE, FAIL).
  - constant FULL_COVERAGE = 16'hFFFF.
  - counter width constant CNT_W = 8.
- Sub-module majority4_ref: combinational reference model.
  - Inputs: 4-bit vector.
  - Output: expected Y.
  - Parameter: TIE_VALUE.
- The checker instantiates majority4_ref once.

## Test plan
- Reset, start, then sweep all 16 vectors with a correct model on Y, one sample per cycle → done=1, pass=1, err_count=0, vec_count=16, coverage=FFFF, 16 cycles after the first sample.
- Same sweep with Y forced 0 on idx 4'b0111, STOP_ON_FAIL=0 → DONE, err_count=1, first_fail_vec=7, pass=0.
- STOP_ON_FAIL=1, Y inverted on idx 4'b0011 (TIE_VALUE=0, so Y=1 is wrong) sampled as the 4th vector → FAIL after 4 samples, vec_count=4, first_fail_vec=3, later samples ignored.
- Sample idx 0 twenty times, then the remaining 15 → vec_count=35, DONE only on the 35th sample.
- start pulsed mid-RUN after 8 samples, together with a sample → counters cleared, that sample discarded, vec_count=0 next cycle, busy=1.
- rst_n dropped asynchronously mid-RUN (between edges) → outputs at reset values immediately. After release, samples are ignored until start.
